// File: rtl/lsu_if.sv
// Data-bus interface between the LSU (master) and the memory system (slave).
// Single outstanding access: the request fields stay stable until ready is seen.
interface lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wstrb, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/lsu.sv
// Load/store unit: two-state (IDLE/WAIT) FSM that issues one word-aligned
// bus access per memory op and returns load data to the register file.
// Non-memory ops pass through to the writeback port with one cycle latency.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned H/W accesses are dropped
// and flagged on misalign_o; without it the low address bits are cleared.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    input  logic        ex_reg_wen_i,
    input  logic        ex_mem_req_i,
    input  logic        ex_mem_we_i,
    input  logic [2:0]  ex_mem_func3_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_mem_wdata_i,
    lsu_if.master       bus,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        reg_wen_o,
    output logic        hold_flag_o,
    output logic        misalign_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic        f3_ok, unaligned, go, mis_hit;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] wrep;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    // Decode the execute-stage request: legality, alignment, lane offset, store lanes.
    always_comb begin
        f3_ok     = ex_mem_we_i ? (ex_mem_func3_i inside {3'b000, 3'b001, 3'b010})
                                : (ex_mem_func3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        unaligned = (ex_mem_func3_i[1:0] == 2'b01 && ex_mem_addr_i[0]) ||
                    (ex_mem_func3_i[1:0] == 2'b10 && ex_mem_addr_i[1:0] != 2'b00);
        off  = ex_mem_addr_i[1:0];
        strb = 4'b0001 << off;
        wrep = {4{ex_mem_wdata_i[7:0]}};
        case (ex_mem_func3_i[1:0])
            2'b01: begin
                off  = {ex_mem_addr_i[1], 1'b0};
                strb = ex_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wrep = {2{ex_mem_wdata_i[15:0]}};
            end
            2'b10: begin
                off  = 2'b00;
                strb = 4'b1111;
                wrep = ex_mem_wdata_i;
            end
            default: ;
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        go      = ex_mem_req_i & f3_ok & ~unaligned;
        mis_hit = ex_mem_req_i & f3_ok & unaligned;
`else
        go      = ex_mem_req_i & f3_ok;
        mis_hit = 1'b0;
`endif
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_v = 8'(bus.rdata >> {off_q, 3'b000});
        half_v = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b100:  load_data = {24'd0, byte_v};
            3'b101:  load_data = {16'd0, half_v};
            default: load_data = bus.rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and stall request; stall is suppressed during reset.
    always_comb begin
        state_nxt   = state;
        hold_flag_o = 1'b0;
        case (state)
            IDLE: if (go) begin
                state_nxt   = WAIT;
                hold_flag_o = 1'b1;
            end
            WAIT: begin
                hold_flag_o = ~bus.ready;
                if (bus.ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) hold_flag_o = 1'b0;
    end

    // Bus request registers, access context and writeback port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.req    <= 1'b0;
            bus.we     <= 1'b0;
            bus.addr   <= '0;
            bus.wstrb  <= '0;
            bus.wdata  <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
            reg_wen_o  <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            reg_wen_o  <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        bus.req   <= 1'b1;
                        bus.we    <= ex_mem_we_i;
                        bus.addr  <= {ex_mem_addr_i[31:2], 2'b00};
                        bus.wstrb <= ex_mem_we_i ? strb : 4'b0000;
                        bus.wdata <= wrep;
                        f3_q      <= ex_mem_func3_i;
                        off_q     <= off;
                        rd_q      <= ex_rd_addr_i;
                    end else if (!ex_mem_req_i) begin
                        reg_wen_o <= ex_reg_wen_i;
                        rd_addr_o <= ex_rd_addr_i;
                        rd_data_o <= ex_rd_data_i;
                    end else begin
                        misalign_o <= mis_hit;
                    end
                end
                WAIT: if (bus.ready) begin
                    bus.req <= 1'b0;
                    if (!bus.we) begin
                        reg_wen_o <= 1'b1;
                        rd_addr_o <= rd_q;
                        rd_data_o <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver pushes expected bus requests and
// writebacks computed from the access rules; monitors pop and compare.
module tb_lsu;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_rd_data;
    logic        ex_reg_wen;
    logic        ex_mem_req;
    logic        ex_mem_we;
    logic [2:0]  ex_mem_func3;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_wen;
    logic        hold_flag;
    logic        misalign;

    lsu_if bus ();

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ex_rd_addr_i(ex_rd_addr), .ex_rd_data_i(ex_rd_data), .ex_reg_wen_i(ex_reg_wen),
        .ex_mem_req_i(ex_mem_req), .ex_mem_we_i(ex_mem_we), .ex_mem_func3_i(ex_mem_func3),
        .ex_mem_addr_i(ex_mem_addr), .ex_mem_wdata_i(ex_mem_wdata),
        .bus(bus.master),
        .rd_addr_o(rd_addr), .rd_data_o(rd_data), .reg_wen_o(reg_wen),
        .hold_flag_o(hold_flag), .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } bus_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

    bus_t exp_bus[$];
    wb_t  exp_wb[$];
    int   total = 0, bad = 0;
    int   mis_exp = 0, mis_seen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit legal(input logic we, input logic [2:0] f3);
        return we ? (f3 < 3) : (f3 < 3 || f3 == 4 || f3 == 5);
    endfunction

    // byte offset within the word after rounding down to the access size
    function automatic int lane(input logic [2:0] f3, input logic [31:0] a);
        int sz, k;
        sz = size_of(f3);
        k  = int'(a % 4);
        return k - (k % sz);
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        int sz;
        sz = size_of(f3);
        v  = w >> (8 * lane(f3, a));
        if (sz == 1) v = f3[2] ? (v & 32'hFF)   : ((v & 32'h80)   != 0 ? (v | 32'hFFFF_FF00) : (v & 32'hFF));
        if (sz == 2) v = f3[2] ? (v & 32'hFFFF) : ((v & 32'h8000) != 0 ? (v | 32'hFFFF_0000) : (v & 32'hFFFF));
        return v;
    endfunction

    // Issue one op at a negedge, play bus slave, and check stall duration.
    task automatic op(input bit mem, input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] rd, input bit rwen,
                      input logic [31:0] rdv, input int lat);
        bit   ok, mis, go;
        int   holds, sz;
        bus_t b;
        sz  = size_of(f3);
        ok  = legal(we, f3);
        mis = (a % sz) != 0;
        go  = mem && ok && !(CHK && mis);
        ex_mem_req   = mem;
        ex_mem_we    = we;
        ex_mem_func3 = f3;
        ex_mem_addr  = a;
        ex_mem_wdata = d;
        ex_rd_data   = d;
        ex_rd_addr   = rd;
        ex_reg_wen   = rwen;
        if (!mem) begin
            if (rwen) exp_wb.push_back('{rd, d});
        end else if (go) begin
            b.we    = we;
            b.addr  = a & ~32'd3;
            b.strb  = 4'((((1 << sz) - 1) << lane(f3, a)));
            b.wdata = (sz == 1) ? (d & 32'hFF) * 32'h0101_0101 :
                      (sz == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
            exp_bus.push_back(b);
            if (!we) exp_wb.push_back('{rd, load_model(f3, a, rdv)});
        end else if (ok && CHK && mis) begin
            mis_exp++;
        end
        #1 holds = int'(hold_flag);
        if (go) begin
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                #1 holds += int'(hold_flag);
            end
            @(negedge clk);
            bus.ready = 1'b1;
            bus.rdata = rdv;
            #1 holds += int'(hold_flag);
            @(negedge clk);
            bus.ready = 1'b0;
            bus.rdata = $urandom;
        end else begin
            @(negedge clk);
        end
        chk("hold_cycles", 32'(holds), go ? 32'(lat + 1) : 32'd0);
    endtask

    // Bus monitor: compare each new request, then require it stay stable.
    initial begin
        bus_t cur;
        bit   active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.req === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected_req", 32'd1, 32'd0);
                        cur = '{bus.we, bus.addr, bus.wstrb, bus.wdata};
                    end else begin
                        cur = exp_bus.pop_front();
                        chk("bus_we", 32'(bus.we), 32'(cur.we));
                        chk("bus_addr", bus.addr, cur.addr);
                        if (cur.we) begin
                            chk("bus_wstrb", 32'(bus.wstrb), 32'(cur.strb));
                            chk("bus_wdata", bus.wdata, cur.wdata);
                        end
                    end
                end else begin
                    chk("bus_stable_addr", bus.addr, cur.addr);
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    // Writeback monitor.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (reg_wen === 1'b1) begin
                if (exp_wb.size() == 0) begin
                    chk("wb_unexpected", {27'd0, rd_addr}, 32'd0);
                end else begin
                    w = exp_wb.pop_front();
                    chk("wb_rd_addr", 32'(rd_addr), 32'(w.rd));
                    chk("wb_rd_data", rd_data, w.data);
                end
            end
            if (misalign === 1'b1) mis_seen++;
        end
    end

    initial begin
        rst_n = 1'b0;
        ex_rd_addr = '0; ex_rd_data = '0; ex_reg_wen = 1'b0;
        ex_mem_req = 1'b0; ex_mem_we = 1'b0; ex_mem_func3 = '0;
        ex_mem_addr = '0; ex_mem_wdata = '0;
        bus.ready = 1'b0; bus.rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(bus.req), 32'd0);
        chk("rst_bus_we", 32'(bus.we), 32'd0);
        chk("rst_bus_addr", bus.addr, 32'd0);
        chk("rst_bus_wstrb", 32'(bus.wstrb), 32'd0);
        chk("rst_bus_wdata", bus.wdata, 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_reg_wen", 32'(reg_wen), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        ex_mem_req = 1'b1; ex_mem_func3 = 3'b010;
        #1 chk("rst_hold", 32'(hold_flag), 32'd0);
        ex_mem_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors
        op(0, 0, 3'b000, 32'h0,   32'h1234_5678, 5'd5, 1, 32'h0, 0);
        op(1, 0, 3'b000, 32'h103, 32'h0,         5'd7, 0, 32'h80FF_FF00, 2);
        op(1, 1, 3'b001, 32'h202, 32'h0000_BEEF, 5'd9, 0, 32'h0, 0);
        op(1, 0, 3'b101, 32'h06,  32'h0,         5'd3, 0, 32'hABCD_0000, 1);
        op(1, 0, 3'b010, 32'h08,  32'h0,         5'd4, 0, 32'hDEAD_BEEF, 0);
        op(1, 0, 3'b010, 32'h101, 32'h0,         5'd6, 0, 32'h1357_9BDF, 1);
        op(1, 1, 3'b010, 32'h33,  32'hCAFE_F00D, 5'd1, 0, 32'h0, 0);
        op(1, 0, 3'b011, 32'h40,  32'h0,         5'd8, 1, 32'h0, 0);
        op(1, 1, 3'b100, 32'h40,  32'h0,         5'd8, 1, 32'h0, 0);
        op(0, 0, 3'b000, 32'h0,   32'h5555_AAAA, 5'd0, 1, 32'h0, 0);
        // ready while idle must be ignored
        bus.ready = 1'b1;
        op(0, 0, 3'b000, 32'h0,   32'h0, 5'd2, 0, 32'h0, 0);
        bus.ready = 1'b0;

        // reset in the middle of a load: access dropped, no writeback
        ex_mem_req = 1'b1; ex_mem_we = 1'b0; ex_mem_func3 = 3'b010; ex_mem_addr = 32'h40;
        ex_rd_addr = 5'd11;
        exp_bus.push_back('{1'b0, 32'h40, 4'h0, 32'h0});
        @(negedge clk);
        chk("wait_bus_req", 32'(bus.req), 32'd1);
        rst_n = 1'b0;
        #1 chk("reset_hold", 32'(hold_flag), 32'd0);
        @(negedge clk);
        chk("reset_bus_req", 32'(bus.req), 32'd0);
        chk("reset_reg_wen", 32'(reg_wen), 32'd0);
        chk("reset_bus_addr", bus.addr, 32'd0);
        rst_n = 1'b1;
        ex_mem_req = 1'b0;
        ex_reg_wen = 1'b0;
        @(negedge clk);
        chk("post_reset_reg_wen", 32'(reg_wen), 32'd0);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            op(($urandom % 4) != 0, $urandom % 2, 3'($urandom), $urandom, $urandom,
               5'($urandom), $urandom % 2, $urandom, int'($urandom_range(0, 3)));
        end

        ex_mem_req = 1'b0;
        ex_reg_wen = 1'b0;
        repeat (3) @(negedge clk);
        chk("wb_left", 32'(exp_wb.size()), 32'd0);
        chk("bus_left", 32'(exp_bus.size()), 32'd0);
        chk("misalign_pulses", 32'(mis_seen), 32'(mis_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
